// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline hazard unit and the datapath forward muxes.
// Tag layout (MSB..LSB): valid, dst, regwrite, memread, md, rs, rt, uses_rs, uses_rt.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Single-bit tag fields: valid, regwrite, memread, md, uses_rs, uses_rt.
    localparam int unsigned TAG_FLAG_W = 6;

    // Total tag width for a register address width of aw (dst, rs, rt plus flags).
    function automatic int unsigned tag_w(input int unsigned aw);
        return 3 * aw + TAG_FLAG_W;
    endfunction

endpackage

// File: rtl/pipe_tag_stage.sv
// One pipeline tag register: async clear, hold keeps the current tag,
// bubble loads an all-zero (invalid) tag.
module pipe_tag_stage #(
    parameter int unsigned W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: forward selects,
// load-use stall, branch flush and the multi-cycle mul/div stall window.
module pipe_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MD_LAT   = 4,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_md,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              md_busy
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              memread;
        logic              md;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
    } tag_t;

    localparam int unsigned TAG_W = tag_w(REG_AW);
    localparam int unsigned CNT_W = $clog2(MD_LAT) + 1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

    tag_t             id_tag;
    tag_t             ex_tag;
    tag_t             mem_tag;
    tag_t             wb_tag;
    logic             load_use;
    logic             ex_bubble;
    logic             md_start;
    logic [CNT_W-1:0] md_cnt;
    logic             unused_tag_bits;

    // True when tag t will write GPR r (register 0 excluded when hardwired).
    function automatic logic writes(input tag_t t, input logic [REG_AW-1:0] r);
        return t.valid && t.regwrite && (t.dst == r) && !(ZERO_REG && (r == '0));
    endfunction

    assign id_tag = '{valid: id_valid, dst: id_dst, regwrite: id_regwrite,
                      memread: id_memread, md: id_md, rs: id_rs, rt: id_rt,
                      uses_rs: id_uses_rs, uses_rt: id_uses_rt};

    always_comb begin
        md_busy  = 1'b0;
        load_use = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;

        md_busy  = (md_cnt != '0);
        load_use = ex_tag.memread &&
                   ((id_uses_rs && writes(ex_tag, id_rs)) ||
                    (id_uses_rt && writes(ex_tag, id_rt)));
        // A held mul/div sits in EX, so a taken-branch indication then is spurious.
        flush    = ex_branch_taken && !md_busy;
        stall    = (load_use || md_busy) && !flush;

        // Newest producer (EX/MEM) takes priority over MEM/WB.
        if (ex_tag.uses_rs && writes(mem_tag, ex_tag.rs)) begin
            fwd_a = FWD_EXMEM;
        end else if (ex_tag.uses_rs && writes(wb_tag, ex_tag.rs)) begin
            fwd_a = FWD_MEMWB;
        end
        if (ex_tag.uses_rt && writes(mem_tag, ex_tag.rt)) begin
            fwd_b = FWD_EXMEM;
        end else if (ex_tag.uses_rt && writes(wb_tag, ex_tag.rt)) begin
            fwd_b = FWD_MEMWB;
        end
    end

    assign ex_bubble = stall || flush || !id_valid;
    assign md_start  = !md_busy && !ex_bubble && id_md;

    // Remaining extra EX cycles of the mul/div currently in EX.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            md_cnt <= '0;
        end else if (md_start) begin
            md_cnt <= MD_LOAD;
        end else if (md_busy) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    pipe_tag_stage #(.W(TAG_W)) u_ex (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .hold   (md_busy),
        .bubble (ex_bubble),
        .d      (id_tag),
        .q      (ex_tag)
    );

    pipe_tag_stage #(.W(TAG_W)) u_mem (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .hold   (1'b0),
        .bubble (md_busy),
        .d      (ex_tag),
        .q      (mem_tag)
    );

    pipe_tag_stage #(.W(TAG_W)) u_wb (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (mem_tag),
        .q      (wb_tag)
    );

    // Late-stage tags carry the full layout for the datapath; only some fields matter here.
    assign unused_tag_bits = ^{ex_tag.md, mem_tag, wb_tag};

endmodule
